axilite_master: RTL and testbench
=================================

Name: axilite_master

Overview:
- AXI-Lite initiator. Converts single-beat read/write commands from a local command port into AXI-Lite address/data/response handshakes.
- Drives the master side of the bus that memory-mapped slaves such as the team's memslave respond on.
- One transaction in flight at a time. Includes a response-timeout watchdog so that a dead slave cannot hang the requester.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr, AXI_AWADDR and AXI_ARADDR.
- DATA_WIDTH, 32, width of data paths.
- TIMEOUT_CYCLES, 16, busy-cycle limit before abort; 0 disables the watchdog.

Ports:
- AXI_ACLK  in  1  clock
- AXI_ARESETN  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted this cycle when cmd_valid is also high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  single-cycle completion pulse
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_timeout  out  1  qualifies rsp_valid; transaction aborted
- AXI_AWADDR out ADDR_WIDTH; AXI_AWVALID out 1; AXI_AWREADY in 1
- AXI_WDATA out DATA_WIDTH; AXI_WVALID out 1; AXI_WREADY in 1
- AXI_BVALID in 1; AXI_BREADY out 1
- AXI_ARADDR out ADDR_WIDTH; AXI_ARVALID out 1; AXI_ARREADY in 1
- AXI_RDATA in DATA_WIDTH; AXI_RVALID in 1; AXI_RREADY out 1

Behaviour:
- Reset: a low AXI_ARESETN sampled at a posedge forces the following, regardless of state, including mid-transaction:
  - all VALID/READY outputs, rsp_valid and rsp_timeout to 0;
  - addresses, WDATA and rsp_rdata to 0;
  - timeout counter to 0; state to IDLE.
- cmd_ready = 1 only in IDLE (combinational from state). The command is captured on cmd_valid && cmd_ready.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE → WR_REQ on a write command.
  - Next cycle: AWVALID = WVALID = 1, with AWADDR/WDATA holding the captured values.
- WR_REQ: AW and W handshakes are tracked independently.
  - Each VALID drops the cycle after its own READY && VALID. If both occur in the same cycle, both drop together.
  - When both have completed → WR_RESP.
- WR_RESP: BREADY = 1 continuously, because the slave may pulse BVALID for a single cycle.
  - On BVALID: BREADY drops next cycle; rsp_valid pulses with rsp_rdata = 0; → IDLE.
- IDLE → RD_REQ on a read command. ARVALID = 1 next cycle with the captured address.
  - On ARREADY: ARVALID drops; → RD_RESP.
- RD_RESP: RREADY = 1 continuously.
  - On RVALID: AXI_RDATA is registered into rsp_rdata and rsp_valid pulses next cycle; → IDLE.
- VALIDs never drop before their handshake (AXI rule). Address/data outputs stay stable while VALID is high.
- Latency against a slave that raises READY one cycle after VALID and returns the response one cycle after the handshake:
  - command accepted at cycle 0;
  - handshake at cycle 2;
  - response at cycle 3;
  - rsp_valid at cycle 4.
- Back-to-back: the next command can be accepted in the same cycle rsp_valid is high (state is already IDLE).
- Watchdog:
  - Counter clears on command acceptance and increments every non-IDLE cycle.
  - If it reaches TIMEOUT_CYCLES without completion, the next cycle:
    - all AXI VALID/READY outputs drop;
    - rsp_valid = rsp_timeout = 1 and rsp_rdata = 0;
    - state → IDLE.
  - Completion in the same cycle as the limit: completion wins and rsp_timeout = 0.
- Counter width is clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- Stray BVALID/RVALID while in IDLE are ignored, because BREADY and RREADY are 0 there.

Decomposition:
- axilite_pkg: state enum typedef (axilite_mst_state_t), default ADDR/DATA widths, and the default timeout constant.
- No sub-module. FSM, capture registers and counter are kept in one module.

Test Plan:
- Write cmd addr 0x05, data 0xDEADBEEF to memslave → AW/W handshake at cycle 2, BVALID at cycle 3, rsp_valid at cycle 4 with rsp_timeout = 0.
- Read addr 0x05 after that write → rsp_valid at cycle 4 with rsp_rdata = 0xDEADBEEF.
- Bench slave asserts AWREADY at cycle 2 but WREADY at cycle 5 → AWVALID drops at cycle 3, WVALID held until cycle 5, single BVALID accepted, single rsp_valid.
- AWREADY tied 0, TIMEOUT_CYCLES = 16 → AWVALID high for cycles 1..16, then rsp_valid = rsp_timeout = 1 at cycle 17, cmd_ready = 1 at cycle 17.
- AXI_ARESETN low for 1 cycle while in RD_RESP → all outputs 0 next cycle, no rsp_valid, and a subsequent read completes normally.
- Two commands held on cmd_valid continuously (write then read) → cmd_ready low while busy; the read is accepted in the same cycle as the write's rsp_valid.

Source files
------------

// File: rtl/axilite_pkg.sv
// Shared state type and default geometry for the AXI-Lite initiator.
package axilite_pkg;

  localparam int AXIL_ADDR_WIDTH     = 32;
  localparam int AXIL_DATA_WIDTH     = 32;
  localparam int AXIL_TIMEOUT_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4
  } axilite_mst_state_t;

endpackage

// File: rtl/axilite_master.sv
// AXI-Lite initiator: one single-beat read or write in flight, with a busy-cycle watchdog.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | cmd_ready high, waiting for a command
//   ST_WR_REQ  | AW and W channels offered, each retired on its own handshake
//   ST_WR_RESP | BREADY held high until the write response arrives
//   ST_RD_REQ  | AR channel offered
//   ST_RD_RESP | RREADY held high until read data arrives
module axilite_master
  import axilite_pkg::*;
#(
  parameter int ADDR_WIDTH     = AXIL_ADDR_WIDTH,
  parameter int DATA_WIDTH     = AXIL_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = AXIL_TIMEOUT_CYCLES
) (
  input  logic                  AXI_ACLK,
  input  logic                  AXI_ARESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] AXI_AWADDR,
  output logic                  AXI_AWVALID,
  input  logic                  AXI_AWREADY,
  output logic [DATA_WIDTH-1:0] AXI_WDATA,
  output logic                  AXI_WVALID,
  input  logic                  AXI_WREADY,
  input  logic                  AXI_BVALID,
  output logic                  AXI_BREADY,
  output logic [ADDR_WIDTH-1:0] AXI_ARADDR,
  output logic                  AXI_ARVALID,
  input  logic                  AXI_ARREADY,
  input  logic [DATA_WIDTH-1:0] AXI_RDATA,
  input  logic                  AXI_RVALID,
  output logic                  AXI_RREADY
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  axilite_mst_state_t state_q, state_d;

  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  arvalid_q, arvalid_d;
  logic                  bready_q, bready_d;
  logic                  rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic                  busy, completing, timeout_hit;

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESETN) begin
      state_q       <= ST_IDLE;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      arvalid_q     <= arvalid_d;
      bready_q      <= bready_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      awaddr_q      <= awaddr_d;
      araddr_q      <= araddr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    arvalid_d     = arvalid_q;
    bready_d      = bready_q;
    rready_d      = rready_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    awaddr_d      = awaddr_q;
    araddr_d      = araddr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    cnt_d         = cnt_q;

    busy        = (state_q != ST_IDLE);
    // cnt_inc counts the current busy cycle, so the limit trips on the last allowed one
    cnt_inc     = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + CNT_W'(1);
    timeout_hit = (TIMEOUT_CYCLES != 0) && busy && (cnt_inc == CNT_LIMIT);
    completing  = ((state_q == ST_WR_RESP) && AXI_BVALID) ||
                  ((state_q == ST_RD_RESP) && AXI_RVALID);

    if (busy) begin
      cnt_d = cnt_inc;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cnt_d = '0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_REQ;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = ST_RD_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        awvalid_d = awvalid_q & ~AXI_AWREADY;
        wvalid_d  = wvalid_q & ~AXI_WREADY;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        if (AXI_BVALID) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rdata_d     = '0;
          state_d     = ST_IDLE;
        end
      end
      ST_RD_REQ: begin
        if (AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_RESP;
        end
      end
      ST_RD_RESP: begin
        if (AXI_RVALID) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rdata_d     = AXI_RDATA;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A response arriving on the limit cycle still counts as a normal completion.
    if (timeout_hit && !completing) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      arvalid_d     = 1'b0;
      bready_d      = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_timeout_d = 1'b1;
      rdata_d       = '0;
      state_d       = ST_IDLE;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_rdata   = rdata_q;
  assign AXI_AWADDR  = awaddr_q;
  assign AXI_AWVALID = awvalid_q;
  assign AXI_WDATA   = wdata_q;
  assign AXI_WVALID  = wvalid_q;
  assign AXI_BREADY  = bready_q;
  assign AXI_ARADDR  = araddr_q;
  assign AXI_ARVALID = arvalid_q;
  assign AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axilite_master.sv
// Randomized bench for axilite_master: latency-programmable slave, queue scoreboard, memory reference model.
module tb_axilite_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;

  axilite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .AXI_ACLK(clk), .AXI_ARESETN(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .AXI_AWADDR(AWADDR), .AXI_AWVALID(AWVALID), .AXI_AWREADY(AWREADY),
    .AXI_WDATA(WDATA), .AXI_WVALID(WVALID), .AXI_WREADY(WREADY),
    .AXI_BVALID(BVALID), .AXI_BREADY(BREADY),
    .AXI_ARADDR(ARADDR), .AXI_ARVALID(ARVALID), .AXI_ARREADY(ARREADY),
    .AXI_RDATA(RDATA), .AXI_RVALID(RVALID), .AXI_RREADY(RREADY)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: one entry per accepted command, in order.
  typedef struct {
    logic        to;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: actual rsp_valid=1 required none (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_timeout", rsp_timeout, mon_e.to);
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_cycle", cyc, mon_e.cyc);
        chk("cmd_ready_at_rsp", cmd_ready, 1'b1);
      end
    end
  end

  // Slave configuration, written only by the stimulus process.
  int aw_lat, w_lat, b_lat, ar_lat, r_lat;
  bit aw_block;
  int flush_req = 0, stray_req = 0;

  // Slave state, written only by the slave process.
  logic [31:0] smem [logic [31:0]];
  int  flush_ack = 0, stray_ack = 0;
  bit  stray_on;
  bit  p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_bv, p_br, p_rv, p_rr;
  logic [31:0] p_awaddr, p_wdata, p_araddr;
  int  aw_cnt, w_cnt, ar_cnt;
  bit  aw_done, w_done, b_pend, r_pend;
  int  b_wait, r_wait;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  int  aw_hs_cyc, w_hs_cyc, ar_hs_cyc, b_hs_cyc;
  int  b_hs_n = 0, awv_high = 0;
  bit  to_now;

  // The slave decides its outputs at the negedge, looking back at the posedge just past.
  always @(negedge clk) begin
    to_now = (rsp_valid === 1'b1) && (rsp_timeout === 1'b1);
    if (flush_req != flush_ack) begin
      flush_ack = flush_req;
      aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0;
    end else begin
      if (p_awv && p_awr) begin
        aw_done = 1; s_awaddr = p_awaddr; aw_hs_cyc = cyc - 1;
        chk("awvalid_drop", AWVALID, 1'b0);
      end else if (p_awv && !to_now) begin
        chk("awvalid_hold", AWVALID, 1'b1);
        chk("awaddr_stable", AWADDR, p_awaddr);
      end
      if (p_wv && p_wr) begin
        w_done = 1; s_wdata = p_wdata; w_hs_cyc = cyc - 1;
        chk("wvalid_drop", WVALID, 1'b0);
      end else if (p_wv && !to_now) begin
        chk("wvalid_hold", WVALID, 1'b1);
        chk("wdata_stable", WDATA, p_wdata);
      end
      if (p_arv && p_arr) begin
        ar_hs_cyc = cyc - 1; s_araddr = p_araddr; r_pend = 1; r_wait = r_lat;
        chk("arvalid_drop", ARVALID, 1'b0);
      end else if (p_arv && !to_now) begin
        chk("arvalid_hold", ARVALID, 1'b1);
        chk("araddr_stable", ARADDR, p_araddr);
      end
      if (p_bv && p_br) begin
        BVALID = 0; b_hs_cyc = cyc - 1; b_hs_n++;
      end
      if (p_rv && p_rr) RVALID = 0;
      if (aw_done && w_done) begin
        smem[s_awaddr] = s_wdata;
        aw_done = 0; w_done = 0; b_pend = 1; b_wait = b_lat;
      end
      if (to_now) begin
        aw_done = 0; w_done = 0; b_pend = 0; r_pend = 0; BVALID = 0; RVALID = 0;
      end
      if (stray_req != stray_ack) begin
        stray_ack = stray_req; stray_on = 1; BVALID = 1; RVALID = 1;
      end else if (stray_on) begin
        stray_on = 0; BVALID = 0; RVALID = 0;
      end
      if (b_pend) begin
        if (b_wait == 0) begin BVALID = 1; b_pend = 0; end
        else b_wait--;
      end
      if (r_pend) begin
        if (r_wait == 0) begin
          RVALID = 1; r_pend = 0;
          RDATA = smem.exists(s_araddr) ? smem[s_araddr] : 32'h0;
        end else r_wait--;
      end
      if (RVALID !== 1'b1) RDATA = $urandom;
      if (AWVALID === 1'b1) begin
        aw_cnt++; awv_high++; AWREADY = !aw_block && (aw_cnt > aw_lat);
      end else begin aw_cnt = 0; AWREADY = 0; end
      if (WVALID === 1'b1) begin
        w_cnt++; WREADY = (w_cnt > w_lat);
      end else begin w_cnt = 0; WREADY = 0; end
      if (ARVALID === 1'b1) begin
        ar_cnt++; ARREADY = (ar_cnt > ar_lat);
      end else begin ar_cnt = 0; ARREADY = 0; end
    end
    p_awv = (AWVALID === 1'b1); p_awr = AWREADY; p_awaddr = AWADDR;
    p_wv  = (WVALID === 1'b1);  p_wr  = WREADY;  p_wdata  = WDATA;
    p_arv = (ARVALID === 1'b1); p_arr = ARREADY; p_araddr = ARADDR;
    p_bv  = BVALID; p_br = (BREADY === 1'b1);
    p_rv  = RVALID; p_rr = (RREADY === 1'b1);
  end

  // Reference model: memory contents plus the expected completion cycle of each command.
  logic [31:0] ref_mem [logic [31:0]];

  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input bit keep, output int acc);
    exp_t e;
    int   n, mx, busy_needed;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (cmd_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL cmd_accept: actual cmd_ready=%b required 1 within 200 cycles", cmd_ready);
    end
    acc = cyc;
    if (wr) begin
      mx = (aw_lat > w_lat) ? aw_lat : w_lat;
      busy_needed = 2 + mx + b_lat;
      e.to = aw_block || (busy_needed > TO);
      e.rdata = 32'h0;
      if (!aw_block) ref_mem[a] = d;
    end else begin
      busy_needed = 2 + ar_lat + r_lat;
      e.to = (busy_needed > TO);
      e.rdata = (!e.to && ref_mem.exists(a)) ? ref_mem[a] : 32'h0;
    end
    e.cyc = e.to ? acc + TO + 1 : acc + busy_needed + 1;
    exp_q.push_back(e);
    @(negedge clk);
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL rsp_wait: actual %0d outstanding required 0 after 100 cycles", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic set_lat(input int a, input int w, input int b, input int ar, input int r);
    aw_lat = a; w_lat = w; b_lat = b; ar_lat = ar; r_lat = r;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_awvalid"}, AWVALID, 1'b0);
    chk({tag, "_wvalid"}, WVALID, 1'b0);
    chk({tag, "_arvalid"}, ARVALID, 1'b0);
    chk({tag, "_bready"}, BREADY, 1'b0);
    chk({tag, "_rready"}, RREADY, 1'b0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_timeout"}, rsp_timeout, 1'b0);
    chk({tag, "_awaddr"}, AWADDR, 32'h0);
    chk({tag, "_araddr"}, ARADDR, 32'h0);
    chk({tag, "_wdata"}, WDATA, 32'h0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual simulation still running required finish (cycle %0d)", cyc);
    $fatal(1, "bench time limit");
  end

  int acc, acc2, bn, ah;
  logic [31:0] d;

  initial begin
    rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    AWREADY = 0; WREADY = 0; ARREADY = 0; BVALID = 0; RVALID = 0; RDATA = '0;
    aw_block = 0;
    set_lat(1, 1, 0, 1, 0);
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Nominal write then read-back against a one-cycle-ready slave.
    issue(1, 32'h5, 32'hDEADBEEF, 0, acc);
    wait_done();
    chk("wr_aw_hs_cycle", aw_hs_cyc, acc + 2);
    chk("wr_w_hs_cycle", w_hs_cyc, acc + 2);
    chk("wr_b_hs_cycle", b_hs_cyc, acc + 3);
    issue(0, 32'h5, 32'h0, 0, acc);
    wait_done();
    chk("rd_ar_hs_cycle", ar_hs_cyc, acc + 2);

    // AW and W complete on different cycles.
    set_lat(1, 4, 0, 1, 0);
    bn = b_hs_n;
    issue(1, 32'h9, 32'h13579BDF, 0, acc);
    wait_done();
    chk("split_aw_hs_cycle", aw_hs_cyc, acc + 2);
    chk("split_w_hs_cycle", w_hs_cyc, acc + 5);
    chk("split_b_count", b_hs_n - bn, 1);

    // Dead AW channel trips the watchdog.
    set_lat(1, 1, 0, 1, 0);
    aw_block = 1;
    ah = awv_high;
    issue(1, 32'hA, 32'h0BADF00D, 0, acc);
    while (cyc < acc + TO + 1) @(negedge clk);
    chk("to_cmd_ready", cmd_ready, 1'b1);
    chk("to_rsp_timeout", rsp_timeout, 1'b1);
    chk("to_awvalid", AWVALID, 1'b0);
    chk("to_wvalid", WVALID, 1'b0);
    chk("to_awvalid_cycles", awv_high - ah, TO);
    wait_done();
    aw_block = 0;

    // Completion exactly on the limit cycle versus one cycle past it.
    for (int k = 0; k < 4; k++) begin
      if (k < 2) begin
        set_lat(7, 7, 7 + k, 1, 0);
        issue(1, 32'hB, $urandom, 0, acc);
      end else begin
        set_lat(1, 1, 0, 7, 5 + k);
        issue(0, 32'hB, 32'h0, 0, acc);
      end
      wait_done();
    end

    // Reset pulse while waiting for read data.
    set_lat(1, 1, 0, 1, 6);
    issue(0, 32'h5, 32'h0, 0, acc);
    while (cyc < acc + 3) @(negedge clk);
    chk("rst_rready_before", RREADY, 1'b1);
    rstn = 1'b0;
    flush_req++;
    exp_q.delete();
    @(negedge clk);
    chk_all_zero("midrst");
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    set_lat(1, 1, 0, 1, 0);
    issue(0, 32'h5, 32'h0, 0, acc);
    wait_done();

    // Stray responses while idle must be ignored.
    stray_req++;
    repeat (4) @(negedge clk);
    chk("stray_cmd_ready", cmd_ready, 1'b1);

    // Back-to-back: read held behind a write is taken on the write's rsp_valid cycle.
    d = $urandom;
    issue(1, 32'hC, d, 1, acc);
    issue(0, 32'hC, 32'h0, 0, acc2);
    chk("b2b_accept_cycle", acc2, acc + 4);
    wait_done();

    // Random traffic with random slave latencies.
    for (int i = 0; i < 120; i++) begin
      set_lat($urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 8),
              $urandom_range(0, 8), $urandom_range(0, 8));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom, 0, acc);
      wait_done();
    end

    repeat (5) @(negedge clk);
    chk("final_outstanding", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
